// File: rtl/tc4_key_accumulator.sv
// Debounced three-key 4-bit two's-complement accumulator (add / subtract / clear)
// with a sticky signed-overflow flag and optional saturation.
module tc4_key_accumulator #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter bit          SATURATE        = 1'b0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       KeyAdd_n,
  input  logic       KeySub_n,
  input  logic       KeyClr_n,
  input  logic [3:0] Step,
  output logic [3:0] N,
  output logic       Overflow,
  output logic       Updated
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } db_state_e;

  logic [2:0] key_raw_n;
  logic [2:0] pulse;

  assign key_raw_n = {KeyClr_n, KeySub_n, KeyAdd_n};

  for (genvar g = 0; g < 3; g++) begin : g_key
    logic [1:0]    sync_q;
    db_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic          armed_q;
    logic          low;

    assign low      = ~sync_q[1];
    assign pulse[g] = (state_q == PRESS_WAIT) && (cnt_q == CW'(DEBOUNCE_CYCLES));

    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
        sync_q  <= '1;
        state_q <= IDLE;
        cnt_q   <= '0;
        armed_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[0], key_raw_n[g]};
        unique case (state_q)
          IDLE: begin
            // After reset IDLE first waits for a debounced release, so a key
            // held across reset cannot fire until it is let go and pressed anew.
            if (!armed_q) begin
              if (low) begin
                cnt_q <= '0;
              end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
                armed_q <= 1'b1;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end else if (low) begin
              cnt_q   <= CW'(1);
              state_q <= PRESS_WAIT;
            end
          end
          PRESS_WAIT: begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
              state_q <= HELD;
              cnt_q   <= '0;
            end else if (low) begin
              cnt_q <= cnt_q + 1'b1;
            end else begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          end
          HELD: begin
            if (!low) begin
              cnt_q   <= CW'(1);
              state_q <= RELEASE_WAIT;
            end
          end
          RELEASE_WAIT: begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (!low) begin
              cnt_q <= cnt_q + 1'b1;
            end else begin
              state_q <= HELD;
              cnt_q   <= '0;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  logic       add_p, sub_p, clr_p;
  logic [4:0] res5;
  logic       ovf;
  logic [3:0] n_q, n_d;
  logic       ovf_q, ovf_d;
  logic       upd_q, upd_d;

  assign add_p = pulse[0];
  assign sub_p = pulse[1];
  assign clr_p = pulse[2];

  always_comb begin
    res5 = add_p ? ({n_q[3], n_q} + {Step[3], Step})
                 : ({n_q[3], n_q} - {Step[3], Step});
    ovf  = res5[4] ^ res5[3];
    n_d   = n_q;
    ovf_d = ovf_q;
    upd_d = 1'b0;
    if (clr_p) begin
      n_d   = '0;
      ovf_d = 1'b0;
      upd_d = 1'b1;
    end else if (add_p ^ sub_p) begin
      upd_d = 1'b1;
      if (ovf) begin
        ovf_d = 1'b1;
        // res5[4] carries the sign of the true (unclipped) result
        if (SATURATE) n_d = res5[4] ? 4'b1000 : 4'b0111;
        else          n_d = res5[3:0];
      end else begin
        n_d = res5[3:0];
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      n_q   <= '0;
      ovf_q <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      n_q   <= n_d;
      ovf_q <= ovf_d;
      upd_q <= upd_d;
    end
  end

  assign N        = n_q;
  assign Overflow = ovf_q;
  assign Updated  = upd_q;

endmodule

// File: tb/tb_tc4_key_accumulator.sv
// Directed bench: a wrapping and a saturating instance share the same key/switch stimulus.
module tb_tc4_key_accumulator;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       add_n, sub_n, clr_n;
  logic [3:0] step;
  logic [3:0] n0, n1;
  logic       ov0, ov1, up0, up1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tc4_key_accumulator #(.DEBOUNCE_CYCLES(D), .SATURATE(1'b0)) dut0 (
    .Clock(clk), .Reset(rst), .KeyAdd_n(add_n), .KeySub_n(sub_n), .KeyClr_n(clr_n),
    .Step(step), .N(n0), .Overflow(ov0), .Updated(up0)
  );

  tc4_key_accumulator #(.DEBOUNCE_CYCLES(D), .SATURATE(1'b1)) dut1 (
    .Clock(clk), .Reset(rst), .KeyAdd_n(add_n), .KeySub_n(sub_n), .KeyClr_n(clr_n),
    .Step(step), .N(n1), .Overflow(ov1), .Updated(up1)
  );

  typedef struct {
    logic [2:0] keys;  // bit0 add, bit1 sub, bit2 clr
    logic [3:0] step;
    logic [3:0] n0;
    logic       ov0;
    logic [3:0] n1;
    logic       ov1;
    logic       upd;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge; keys fall before the next rising edge (edge k).
  task automatic press(input logic [2:0] keys, input logic [3:0] stp,
                       input logic [3:0] en0, input logic eo0,
                       input logic [3:0] en1, input logic eo1,
                       input logic eupd, input string tag);
    logic [3:0] pn0, pn1;
    pn0   = n0;
    pn1   = n1;
    step  = stp;
    add_n = ~keys[0];
    sub_n = ~keys[1];
    clr_n = ~keys[2];
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (i == 5) begin
        chk({tag, " early upd0"}, int'(up0), 0);
        chk({tag, " early upd1"}, int'(up1), 0);
        chk({tag, " early n0"}, int'(n0), int'(pn0));
        chk({tag, " early n1"}, int'(n1), int'(pn1));
      end
      if (i == 6) begin
        chk({tag, " n0"}, int'(n0), int'(en0));
        chk({tag, " ov0"}, int'(ov0), int'(eo0));
        chk({tag, " n1"}, int'(n1), int'(en1));
        chk({tag, " ov1"}, int'(ov1), int'(eo1));
        chk({tag, " upd0"}, int'(up0), int'(eupd));
        chk({tag, " upd1"}, int'(up1), int'(eupd));
        step = ~stp;
      end
      if (i == 7) begin
        chk({tag, " upd0 one cycle"}, int'(up0), 0);
        chk({tag, " n0 hold"}, int'(n0), int'(en0));
        chk({tag, " n1 hold"}, int'(n1), int'(en1));
      end
    end
    add_n = 1'b1;
    sub_n = 1'b1;
    clr_n = 1'b1;
    repeat (12) cyc();
  endtask

  initial begin
    int npulse;

    vecs[0]  = '{3'b001, 4'b0011, 4'b0011, 1'b0, 4'b0011, 1'b0, 1'b1};
    vecs[1]  = '{3'b001, 4'b0011, 4'b0110, 1'b0, 4'b0110, 1'b0, 1'b1};
    vecs[2]  = '{3'b001, 4'b0011, 4'b1001, 1'b1, 4'b0111, 1'b1, 1'b1};
    vecs[3]  = '{3'b100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1};
    vecs[4]  = '{3'b010, 4'b1000, 4'b1000, 1'b1, 4'b0111, 1'b1, 1'b1};
    vecs[5]  = '{3'b100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1};
    vecs[6]  = '{3'b011, 4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
    vecs[7]  = '{3'b001, 4'b0101, 4'b0101, 1'b0, 4'b0101, 1'b0, 1'b1};
    vecs[8]  = '{3'b010, 4'b0010, 4'b0011, 1'b0, 4'b0011, 1'b0, 1'b1};
    vecs[9]  = '{3'b111, 4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1};
    vecs[10] = '{3'b010, 4'b0011, 4'b1101, 1'b0, 4'b1101, 1'b0, 1'b1};
    vecs[11] = '{3'b001, 4'b1000, 4'b0101, 1'b1, 4'b1000, 1'b1, 1'b1};
    vecs[12] = '{3'b010, 4'b1111, 4'b0110, 1'b1, 4'b1001, 1'b1, 1'b1};
    vecs[13] = '{3'b100, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1};

    rst   = 1'b1;
    add_n = 1'b1;
    sub_n = 1'b1;
    clr_n = 1'b1;
    step  = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    chk("reset n0", int'(n0), 0);
    chk("reset n1", int'(n1), 0);
    chk("reset ov0", int'(ov0), 0);
    chk("reset ov1", int'(ov1), 0);
    chk("reset upd0", int'(up0), 0);
    chk("reset upd1", int'(up1), 0);
    rst = 1'b0;
    repeat (10) cyc();

    for (int v = 0; v < 14; v++) begin
      press(vecs[v].keys, vecs[v].step, vecs[v].n0, vecs[v].ov0,
            vecs[v].n1, vecs[v].ov1, vecs[v].upd, $sformatf("vec%0d", v));
    end

    // Press bounce: low 3, high 1, then low 20; single pulse 4 stable samples after last fall.
    step   = 4'b0001;
    npulse = 0;
    add_n  = 1'b0;
    repeat (3) begin cyc(); npulse += int'(up0); end
    add_n = 1'b1;
    cyc(); npulse += int'(up0);
    add_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      npulse += int'(up0);
      if (i == 5) chk("bounce early n0", int'(n0), 0);
      if (i == 6) begin
        chk("bounce n0", int'(n0), 1);
        chk("bounce n1", int'(n1), 1);
        chk("bounce upd0", int'(up0), 1);
      end
    end
    // Release bounce: high 2, low 1, high 10.
    add_n = 1'b1;
    repeat (2) begin cyc(); npulse += int'(up0); end
    add_n = 1'b0;
    cyc(); npulse += int'(up0);
    add_n = 1'b1;
    repeat (14) begin cyc(); npulse += int'(up0); end
    chk("bounce pulse count", npulse, 1);
    chk("bounce final n0", int'(n0), 1);

    // Reset while Add is in PRESS_WAIT, key held through deassertion.
    step  = 4'b0010;
    add_n = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
    #1;
    chk("mid reset n0", int'(n0), 0);
    chk("mid reset n1", int'(n1), 0);
    chk("mid reset upd0", int'(up0), 0);
    @(negedge clk);
    chk("mid reset ov0", int'(ov0), 0);
    cyc();
    rst    = 1'b0;
    npulse = 0;
    repeat (20) begin cyc(); npulse += int'(up0) + int'(up1); end
    chk("held through reset no pulse", npulse, 0);
    chk("held through reset n0", int'(n0), 0);
    add_n = 1'b1;
    repeat (8) cyc();
    press(3'b001, 4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b0, 1'b1, "post reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
